prog_interval_timer: RTL and testbench

PROG_INTERVAL_TIMER -- requirements
Module: prog_interval_timer

---
 rtl/prog_interval_timer.sv | 130 +++++++++++++
 tb/tb_prog_interval_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_interval_timer.sv
// prog_interval_timer
//   Programmable interval timer. On start it latches a period chosen by level_index and counts
//   down once per clock. When the count runs out it emits a single-cycle pulse. It then either
//   reloads the period (periodic) or returns to idle (one-shot).
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   start        in   latch level_index/periodic and (re)start the countdown
//   stop         in   abort the countdown and return to idle
//   periodic     in   sampled with start: 1 = auto-reload, 0 = one-shot
//   pause        in   freeze the countdown while high
//   level_index  in   period select, sampled only on start
//   pulse        out  registered single-cycle terminal pulse
//   busy         out  high while in the run state
//   remaining    out  current countdown value
//   pulse_cnt    out  pulses since the last start, wraps 255 -> 0
module prog_interval_timer #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned BASE       = 32000000,
    parameter int unsigned STEP       = 1000000,
    parameter int unsigned MIN_PERIOD = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             pause,
    input  logic [IDX_W-1:0] level_index,
    output logic             pulse,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [7:0]       pulse_cnt
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Wide enough that BASE - STEP*index cannot lose bits before the clamp decision.
    localparam int unsigned WIDE = CNT_W + IDX_W + 1;
    localparam logic [WIDE-1:0] BASE_WIDE = WIDE'(BASE);
    localparam logic [WIDE-1:0] STEP_WIDE = WIDE'(STEP);
    localparam logic [WIDE-1:0] MIN_WIDE  = WIDE'(MIN_PERIOD);

    logic             state_q, state_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;

    logic [WIDE-1:0]  step_prod;
    logic [WIDE-1:0]  base_diff;
    logic [WIDE-1:0]  period_wide;
    logic [CNT_W-1:0] period_new;

    // Period lookup: linear reduction from BASE, clamped at MIN_PERIOD (also covers underflow).
    always_comb begin
        step_prod = STEP_WIDE * WIDE'(level_index);
        base_diff = BASE_WIDE - step_prod;
        if ((step_prod > BASE_WIDE) || (base_diff < MIN_WIDE)) begin
            period_wide = MIN_WIDE;
        end else begin
            period_wide = base_diff;
        end
        period_new = period_wide[CNT_W-1:0];
    end

    // Priority: stop > start > pause > countdown (reset handled in the register block).
    always_comb begin
        state_d     = state_q;
        pulse_d     = 1'b0;
        remaining_d = remaining_q;
        pulse_cnt_d = pulse_cnt_q;
        period_d    = period_q;
        mode_d      = mode_q;

        if (stop) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (start) begin
            // A start on the terminal edge restarts and swallows that pulse.
            state_d     = ST_RUN;
            period_d    = period_new;
            mode_d      = periodic;
            remaining_d = period_new;
            pulse_cnt_d = 8'd0;
        end else if (state_q == ST_RUN && !pause) begin
            // <= 1 so a zero count can never wedge the timer in run.
            if (remaining_q <= CNT_W'(1)) begin
                pulse_d     = 1'b1;
                pulse_cnt_d = pulse_cnt_q + 8'd1;
                if (mode_q) begin
                    remaining_d = period_q;
                end else begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end
            end else begin
                remaining_d = remaining_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pulse_q     <= 1'b0;
            remaining_q <= '0;
            pulse_cnt_q <= 8'd0;
            period_q    <= MIN_WIDE[CNT_W-1:0];
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            remaining_q <= remaining_d;
            pulse_cnt_q <= pulse_cnt_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
        end
    end

    assign pulse     = pulse_q;
    assign busy      = (state_q == ST_RUN);
    assign remaining = remaining_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_prog_interval_timer.sv
// tb_prog_interval_timer
//   Directed bench for prog_interval_timer with CNT_W=8, IDX_W=3, BASE=20, STEP=3,
//   MIN_PERIOD=2. Period table: idx0=20, 1=17, 2=14, 3=11, 4=8, 5=5, 6=2, 7=2 (clamped).
module tb_prog_interval_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       periodic;
    logic       pause;
    logic [2:0] level_index;
    logic       pulse;
    logic       busy;
    logic [7:0] remaining;
    logic [7:0] pulse_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_interval_timer #(
        .CNT_W      (8),
        .IDX_W      (3),
        .BASE       (20),
        .STEP       (3),
        .MIN_PERIOD (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .periodic    (periodic),
        .pause       (pause),
        .level_index (level_index),
        .pulse       (pulse),
        .busy        (busy),
        .remaining   (remaining),
        .pulse_cnt   (pulse_cnt)
    );

    typedef struct {
        logic       rst;
        logic       sta;
        logic       stp;
        logic       per;
        logic       pau;
        logic [2:0] idx;
        logic       e_pulse;
        logic       e_busy;
        int         e_rem;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic sta, logic stp, logic per, logic pau,
                                logic [2:0] idx, logic ep, logic eb, int er, int ec);
        vec_t v;
        v.rst = rst; v.sta = sta; v.stp = stp; v.per = per; v.pau = pau; v.idx = idx;
        v.e_pulse = ep; v.e_busy = eb; v.e_rem = er; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic sta, input logic stp, input logic per,
                         input logic pau, input logic [2:0] idx);
        reset = rst; start = sta; stop = stp; periodic = per; pause = pau; level_index = idx;
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, periodic, 1'b0, level_index);
    endtask

    task automatic chk_outs(input string tag, input int ep, input int eb, input int er,
                            input int ec);
        chk({tag, ".pulse"}, int'(pulse), ep);
        chk({tag, ".busy"}, int'(busy), eb);
        chk({tag, ".remaining"}, int'(remaining), er);
        chk({tag, ".pulse_cnt"}, int'(pulse_cnt), ec);
    endtask

    initial begin
        int first_pulse;
        int npulse;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        //               rst sta stp per pau idx  pulse busy rem cnt
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));   // reset state
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));   // idle holds
        vecs.push_back(mk(0, 1, 0, 0, 0, 3'd5, 0, 1, 5, 0));   // one-shot P=5
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd5, 0, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'd5, 0, 1, 4, 0));   // pause freezes
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'd5, 0, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd5, 0, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd5, 0, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd5, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd5, 1, 0, 0, 1));   // terminal, one-shot ends
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3'd5, 0, 0, 0, 1));   // pause ignored in idle
        vecs.push_back(mk(0, 1, 0, 1, 0, 3'd6, 0, 1, 2, 0));   // periodic P=2
        vecs.push_back(mk(0, 0, 0, 1, 0, 3'd6, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3'd6, 1, 1, 2, 1));   // reload
        vecs.push_back(mk(0, 0, 0, 1, 0, 3'd6, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3'd6, 1, 1, 2, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 2));   // idx/periodic ignored
        vecs.push_back(mk(0, 1, 0, 1, 0, 3'd7, 0, 1, 2, 0));   // start on terminal edge
        vecs.push_back(mk(0, 0, 1, 1, 0, 3'd7, 0, 0, 0, 0));   // stop
        vecs.push_back(mk(0, 1, 0, 1, 0, 3'd0, 0, 1, 20, 0));  // P=20
        vecs.push_back(mk(0, 1, 1, 1, 0, 3'd0, 0, 0, 0, 0));   // stop beats start
        vecs.push_back(mk(0, 1, 0, 0, 0, 3'd4, 0, 1, 8, 0));   // P=8
        vecs.push_back(mk(1, 1, 1, 1, 1, 3'd4, 0, 0, 0, 0));   // reset beats all

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].sta, vecs[i].stp, vecs[i].per, vecs[i].pau, vecs[i].idx);
            step();
            chk_outs($sformatf("vec%0d", i), int'(vecs[i].e_pulse), int'(vecs[i].e_busy),
                     vecs[i].e_rem, vecs[i].e_cnt);
        end

        // One-shot idx=0: single pulse in the cycle after edge E0+20.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        first_pulse = -1;
        npulse = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (pulse) begin
                npulse++;
                if (first_pulse < 0) first_pulse = k;
            end
        end
        chk("oneshot.first_pulse", first_pulse, 20);
        chk("oneshot.pulses", npulse, 1);
        chk("oneshot.busy", int'(busy), 0);
        chk("oneshot.pulse_cnt", int'(pulse_cnt), 1);

        // Periodic idx=5: pulses every 5 cycles, count climbs.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
        step();
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("per5.pulse@%0d", k), int'(pulse), (k % 5 == 0) ? 1 : 0);
            chk($sformatf("per5.cnt@%0d", k), int'(pulse_cnt), k / 5);
        end

        // Pause mid-count delays one-shot idx=5 pulse by 4 cycles.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
        step();
        step();
        step();
        chk("pause.before", int'(remaining), 3);
        for (int k = 0; k < 4; k++) begin
            pause = 1'b1;
            step();
            chk($sformatf("pause.frozen%0d", k), int'(remaining), 3);
            chk($sformatf("pause.nopulse%0d", k), int'(pulse), 0);
        end
        step();
        step();
        chk("pause.late", int'(pulse), 0);
        step();
        chk("pause.pulse", int'(pulse), 1);
        chk("pause.idle", int'(busy), 0);

        // Retrigger: periodic idx=0, start idx=5 exactly on the second terminal edge.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        step();
        for (int k = 1; k <= 39; k++) step();
        chk("retrig.rem_before", int'(remaining), 1);
        chk("retrig.cnt_before", int'(pulse_cnt), 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
        step();
        chk_outs("retrig.start", 0, 1, 5, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("retrig.pulse@%0d", k), int'(pulse), (k == 5) ? 1 : 0);
        end
        chk("retrig.cnt_after", int'(pulse_cnt), 1);

        // Stop at remaining=3: no pulse, idle, cleared.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        for (int k = 1; k <= 17; k++) step();
        chk("stop.rem3", int'(remaining), 3);
        stop = 1'b1;
        step();
        chk_outs("stop.after", 0, 0, 0, 0);
        npulse = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (pulse) npulse++;
        end
        chk("stop.nopulse", npulse, 0);

        // Wrap: periodic idx=7 (P=2 clamped), 256 pulses bring pulse_cnt back to 0.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7);
        step();
        npulse = 0;
        for (int k = 1; k <= 512; k++) begin
            step();
            if (pulse != ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
                chk($sformatf("wrap.pulse@%0d", k), int'(pulse), (k % 2 == 0) ? 1 : 0);
            end
            if (pulse) npulse++;
        end
        chk("wrap.pulses", npulse, 256);
        chk("wrap.cnt", int'(pulse_cnt), 0);
        chk("wrap.busy", int'(busy), 1);

        // Reset coincident with terminal edge: no pulse.
        step();
        chk("rst_term.rem1", int'(remaining), 1);
        reset = 1'b1;
        step();
        chk_outs("rst_term", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
